// File: rtl/fc_classify_pkg.sv
// rtl/fc_classify_pkg.sv - shared fixed-point constants, FSM states and score rounding
// Scores are signed 4.16; the accumulator keeps 32 fractional bits until round_sat.
package fc_classify_pkg;

  localparam int FRAC      = 16;
  localparam int W         = 20;
  localparam int ACCW      = 52;
  localparam int PRODW     = 41;
  localparam int NFEAT_DEF = 1024;

  localparam logic [W-1:0] SAT_POS = 20'h7FFFF;
  localparam logic [W-1:0] SAT_NEG = 20'h80000;

  localparam logic signed [ACCW-1:0] HALF_LSB = ACCW'(1) << (FRAC - 1);
  localparam logic signed [ACCW-1:0] LIM_HI   = {{(ACCW-W-FRAC){1'b0}}, SAT_POS, {FRAC{1'b0}}};
  localparam logic signed [ACCW-1:0] LIM_LO   = {{(ACCW-W-FRAC){1'b1}}, SAT_NEG, {FRAC{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  // Round half-up at the score LSB, then clamp to the 20-bit signed range.
  function automatic logic [W-1:0] round_sat(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] r;
    r = acc + HALF_LSB;
    if (r > LIM_HI) begin
      return SAT_POS;
    end else if (r < LIM_LO) begin
      return SAT_NEG;
    end else begin
      return r[FRAC+W-1:FRAC];
    end
  endfunction

endpackage

// File: rtl/fc_classify_mac.sv
// rtl/fc_classify_mac.sv - two-stage multiply-accumulate: registered product, then accumulate
// acc_o already includes the product sitting in stage 1, so a caller can read the final sum one cycle early.
module fc_mac
  import fc_classify_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [W-1:0]           a_i,
  input  logic [W-1:0]           b_i,
  output logic signed [ACCW-1:0] acc_o
);

  logic signed [PRODW-1:0] prod_q;
  logic signed [PRODW-1:0] prod_d;
  logic                    pvalid_q;
  logic signed [ACCW-1:0]  acc_q;
  logic signed [ACCW-1:0]  acc_d;

  // a_i is an unsigned feature, b_i a signed weight; both widened to the product width.
  always_comb begin
    prod_d = $signed({{(PRODW-W){1'b0}}, a_i}) * $signed({{(PRODW-W){b_i[W-1]}}, b_i});
    acc_d  = acc_q;
    if (pvalid_q) begin
      acc_d = acc_q + $signed({{(ACCW-PRODW){prod_q[PRODW-1]}}, prod_q});
    end
  end

  assign acc_o = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      pvalid_q <= 1'b0;
      acc_q    <= '0;
    end else if (clear_i) begin
      prod_q   <= '0;
      pvalid_q <= 1'b0;
      acc_q    <= '0;
    end else if (en_i) begin
      prod_q   <= prod_d;
      pvalid_q <= valid_i;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/fc_classify.sv
// rtl/fc_classify.sv - per-class dot product of the pooled feature map, score write and arg-max
// One pass over the feature map per class; the MAC is cleared between classes.
module fc_classify
  import fc_classify_pkg::*;
#(
  parameter int NCLASS = 4,
  parameter int NFEAT  = NFEAT_DEF,
  parameter int WAW    = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ready,
  output logic           busy,
  output logic           frd,
  output logic [9:0]     faddr,
  input  logic [W-1:0]   fdata,
  output logic [WAW-1:0] waddr,
  input  logic [W-1:0]   wdata,
  output logic           swr,
  output logic [3:0]     saddr,
  output logic [W-1:0]   sdata,
  output logic [3:0]     class_id,
  output logic           done
);

  state_t                 state_q;
  logic [3:0]             cls_q;
  logic [9:0]             idx_q;
  logic                   drain_q;
  logic                   frd_q;
  logic                   frd_dly_q;
  logic                   busy_q;
  logic [WAW-1:0]         waddr_q;
  logic                   swr_q;
  logic [3:0]             saddr_q;
  logic [W-1:0]           sdata_q;
  logic [3:0]             class_id_q;
  logic                   done_q;
  logic [W-1:0]           max_q;
  logic [3:0]             best_q;

  logic                   last_cls;
  logic                   take_d;
  logic [W-1:0]           max_d;
  logic [3:0]             best_d;
  logic                   clear_d;
  logic signed [ACCW-1:0] acc;

  always_comb begin
    last_cls = (cls_q == 4'(NCLASS - 1));
    take_d   = (cls_q == 4'd0) || ($signed(sdata_q) > $signed(max_q));
    max_d    = take_d ? sdata_q : max_q;
    best_d   = take_d ? cls_q : best_q;
    clear_d  = ((state_q == S_IDLE) && ready) || ((state_q == S_WRITE) && !last_cls);
  end

  // Memory data lags the address by one cycle, so the MAC valid is frd delayed once.
  fc_mac u_mac (
    .clk     (clk),
    .rst     (reset),
    .clear_i (clear_d),
    .en_i    (busy_q),
    .valid_i (frd_dly_q),
    .a_i     (fdata),
    .b_i     (wdata),
    .acc_o   (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cls_q      <= '0;
      idx_q      <= '0;
      drain_q    <= 1'b0;
      frd_q      <= 1'b0;
      frd_dly_q  <= 1'b0;
      busy_q     <= 1'b0;
      waddr_q    <= '0;
      swr_q      <= 1'b0;
      saddr_q    <= '0;
      sdata_q    <= '0;
      class_id_q <= '0;
      done_q     <= 1'b0;
      max_q      <= '0;
      best_q     <= '0;
    end else begin
      frd_dly_q <= frd_q;
      case (state_q)
        S_IDLE: begin
          if (ready) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            frd_q   <= 1'b1;
            cls_q   <= '0;
            idx_q   <= '0;
            waddr_q <= '0;
          end
        end
        S_FETCH: begin
          if (idx_q == 10'(NFEAT - 1)) begin
            state_q <= S_DRAIN;
            frd_q   <= 1'b0;
            drain_q <= 1'b0;
          end else begin
            idx_q   <= idx_q + 10'd1;
            waddr_q <= waddr_q + WAW'(1);
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= S_WRITE;
            swr_q   <= 1'b1;
            saddr_q <= cls_q;
            sdata_q <= round_sat(acc);
          end
        end
        S_WRITE: begin
          swr_q  <= 1'b0;
          max_q  <= max_d;
          best_q <= best_d;
          if (last_cls) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            class_id_q <= best_d;
          end else begin
            // Class blocks are contiguous, so the next base is one past the last weight read.
            state_q <= S_FETCH;
            cls_q   <= cls_q + 4'd1;
            idx_q   <= '0;
            waddr_q <= waddr_q + WAW'(1);
            frd_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign frd      = frd_q;
  assign faddr    = idx_q;
  assign waddr    = waddr_q;
  assign swr      = swr_q;
  assign saddr    = saddr_q;
  assign sdata    = sdata_q;
  assign class_id = class_id_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fc_classify.sv
// tb/tb_fc_classify.sv - self-checking bench for fc_classify
module tb_fc_classify;

  localparam int NCLASS = 4;
  localparam int NFEAT  = 1024;
  localparam int WAW    = 12;
  localparam int LAT    = NCLASS * 1027 + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           ready;
  logic           busy, frd, swr, done;
  logic [9:0]     faddr;
  logic [19:0]    fdata, wdata, sdata;
  logic [WAW-1:0] waddr;
  logic [3:0]     saddr, class_id;

  fc_classify #(.NCLASS(NCLASS), .NFEAT(NFEAT), .WAW(WAW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .frd(frd),
    .faddr(faddr), .fdata(fdata), .waddr(waddr), .wdata(wdata),
    .swr(swr), .saddr(saddr), .sdata(sdata), .class_id(class_id), .done(done)
  );

  always #5 clk = ~clk;

  logic [19:0] feat [NFEAT];
  logic [19:0] wt   [NCLASS*NFEAT];

  always @(posedge clk) begin
    fdata <= feat[faddr];
    wdata <= wt[waddr];
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  int          swr_cnt = 0;
  int          done_cnt = 0;
  int          overlap_cnt = 0;
  logic [3:0]  got_addr [64];
  logic [19:0] got_data [64];
  logic [3:0]  got_cls = '0;

  always @(negedge clk) begin
    if (swr) begin
      got_addr[swr_cnt % 64] = saddr;
      got_data[swr_cnt % 64] = sdata;
      swr_cnt++;
    end
    if (done) begin
      done_cnt++;
      got_cls = class_id;
    end
    if (swr && done) overlap_cnt++;
  end

  int exp_score [NCLASS];
  int exp_cls;

  function automatic int to_signed20(input int v);
    return (v >= 'h80000) ? v - 'h100000 : v;
  endfunction

  // Exact dot products in 64-bit integers, then the rounding/saturation rule and strict arg-max.
  function automatic void model();
    longint acc, r;
    for (int c = 0; c < NCLASS; c++) begin
      acc = 0;
      for (int i = 0; i < NFEAT; i++)
        acc += longint'(feat[i]) * longint'($signed(wt[c*NFEAT+i]));
      r = acc + 32768;
      if (r > 64'sh7FFFF * 65536) exp_score[c] = 'h7FFFF;
      else if (r < -(64'sh80000 * 65536)) exp_score[c] = 'h80000;
      else exp_score[c] = int'((r >>> 16) & 64'hFFFFF);
    end
    exp_cls = 0;
    for (int c = 1; c < NCLASS; c++)
      if (to_signed20(exp_score[c]) > to_signed20(exp_score[exp_cls])) exp_cls = c;
  endfunction

  task automatic run_once(input int p1, input int p2, output int lat);
    int n;
    n = 0;
    lat = -1;
    @(negedge clk);
    ready = 1'b1;
    while (n < 6000) begin
      @(posedge clk);
      n++;
      #1;
      ready = (n == p1) || (n == p2);
      if (done) begin
        lat = n;
        break;
      end
    end
    ready = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input int lat, input int sbase, input int dbase);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_swr_count"}, swr_cnt - sbase, NCLASS);
    check({tag, "_done_count"}, done_cnt - dbase, 1);
    for (int c = 0; c < NCLASS; c++) begin
      check($sformatf("%s_saddr%0d", tag, c), got_addr[(sbase + c) % 64], c);
      check($sformatf("%s_score%0d", tag, c), got_data[(sbase + c) % 64], exp_score[c]);
    end
    check({tag, "_class_id"}, got_cls, exp_cls);
    check({tag, "_swr_done_overlap"}, overlap_cnt, 0);
  endtask

  task automatic fill(input int mode, input logic [19:0] fv, input logic [19:0] wv);
    logic [31:0] r;
    for (int i = 0; i < NFEAT; i++) begin
      case (mode)
        0: feat[i] = fv;
        1: feat[i] = (i == 5) ? 20'h20000 : 20'h0;
        2: feat[i] = 20'h10000;
        3: feat[i] = 20'($urandom) & 20'h0FFFF;
        default: feat[i] = 20'($urandom);
      endcase
      for (int c = 0; c < NCLASS; c++) begin
        r = $urandom;
        case (mode)
          0: wt[c*NFEAT+i] = wv;
          1: wt[c*NFEAT+i] = (i == 5) ? 20'(c * 'h8000) : 20'h0;
          2: wt[c*NFEAT+i] = (c == 1) ? 20'hF0000 : 20'((c + 1) * 'h40);
          3: wt[c*NFEAT+i] = {{4{r[15]}}, r[15:0]};
          default: wt[c*NFEAT+i] = r[19:0];
        endcase
      end
    end
  endtask

  typedef struct packed {
    int                     mode;
    logic [19:0]            fv;
    logic [19:0]            wv;
    logic [NCLASS-1:0][19:0] s;
    int                     cls;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat, sb, db;
    reset = 1'b1;
    ready = 1'b0;
    fill(0, 20'h0, 20'h0);

    vecs[0] = '{mode: 0, fv: 20'h10000, wv: 20'h10000,
                s: {20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF}, cls: 0};
    vecs[1] = '{mode: 1, fv: 20'h0, wv: 20'h0,
                s: {20'h30000, 20'h20000, 20'h10000, 20'h00000}, cls: 3};
    vecs[2] = '{mode: 0, fv: 20'h00001, wv: 20'h08000,
                s: {20'h00200, 20'h00200, 20'h00200, 20'h00200}, cls: 0};
    vecs[3] = '{mode: 0, fv: 20'h00001, wv: 20'h00001,
                s: {20'h0, 20'h0, 20'h0, 20'h0}, cls: 0};
    vecs[4] = '{mode: 2, fv: 20'h0, wv: 20'h0,
                s: {20'h40000, 20'h30000, 20'h80000, 20'h10000}, cls: 3};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_frd", frd, 0);
    check("rst_faddr", faddr, 0);
    check("rst_waddr", waddr, 0);
    check("rst_swr", swr, 0);
    check("rst_saddr", saddr, 0);
    check("rst_sdata", sdata, 0);
    check("rst_class_id", class_id, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].mode, vecs[v].fv, vecs[v].wv);
      for (int c = 0; c < NCLASS; c++) exp_score[c] = int'(vecs[v].s[c]);
      exp_cls = vecs[v].cls;
      sb = swr_cnt;
      db = done_cnt;
      run_once(-1, -1, lat);
      verify($sformatf("vec%0d", v), lat, sb, db);
    end

    for (int k = 0; k < 3; k++) begin
      fill((k == 1) ? 4 : 3, 20'h0, 20'h0);
      model();
      sb = swr_cnt;
      db = done_cnt;
      run_once(-1, -1, lat);
      verify($sformatf("rand%0d", k), lat, sb, db);
    end

    // Reset during class 1 fetch, then a clean rerun.
    fill(3, 20'h0, 20'h0);
    model();
    sb = swr_cnt;
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (1499) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_frd", frd, 0);
    check("midrst_faddr", faddr, 0);
    check("midrst_waddr", waddr, 0);
    check("midrst_swr", swr, 0);
    check("midrst_sdata", sdata, 0);
    check("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_swr_before_reset", swr_cnt - sb, 1);
    sb = swr_cnt;
    db = done_cnt;
    run_once(-1, -1, lat);
    verify("rerun", lat, sb, db);

    // Ready pulses while busy must be ignored.
    sb = swr_cnt;
    db = done_cnt;
    run_once(10, 2000, lat);
    verify("busy_ready", lat, sb, db);
    repeat (3) @(negedge clk);
    check("busy_ready_no_restart", busy, 0);

    // Ready held high across DONE: one IDLE cycle, then a fresh start at address 0.
    begin
      int n;
      n = 0;
      @(negedge clk);
      ready = 1'b1;
      while (n < 6000 && !done) begin
        @(posedge clk);
        n++;
        #1;
      end
      check("hold_latency", n, LAT);
      @(posedge clk);
      #1;
      check("hold_idle_busy", busy, 0);
      check("hold_idle_frd", frd, 0);
      @(posedge clk);
      #1;
      check("hold_restart_busy", busy, 1);
      check("hold_restart_frd", frd, 1);
      check("hold_restart_faddr", faddr, 0);
      check("hold_restart_waddr", waddr, 0);
      ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fc_classify.md
# fc_classify

Fully-connected classification stage directly downstream of the convolution/max-pool engine. Once layer-1 memory holds the 32x32 max-pooled feature map (1024 unsigned 20-bit words, 4.16 fixed point, post-ReLU), this block streams the map once per class against a per-class weight vector and accumulates the dot product. It writes one rounded, saturated score per class to a score memory and reports the arg-max class index.

## Interface
- NCLASS, 4: number of output classes (2..16)
- NFEAT, 1024: feature words per class (fixed by the 32x32 pooled map)
- WAW, 12: weight address width, equal to clog2(NCLASS*NFEAT)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- ready  in  1  start request; sampled only in IDLE
- busy  out  1  high from the cycle after the accepted ready until DONE completes
- frd  out  1  feature-memory read enable
- faddr  out  10  feature address (layer-1 index)
- fdata  in  20  feature data, unsigned 4.16
- waddr  out  WAW  weight address = class*NFEAT + feature index
- wdata  in  20  weight data, signed two's complement 4.16
- swr  out  1  score write strobe, one cycle per class
- saddr  out  4  score address = class index
- sdata  out  20  score, signed 4.16
- class_id  out  4  arg-max class; valid while done=1
- done  out  1  one-cycle pulse after the last score write

## Operation
- Both memories are synchronous-read: data for an address driven in cycle k is valid in cycle k+1.
- The feature and weight addresses always advance together.
- State machine:
  - IDLE: busy=0. ready=1 moves to FETCH, clears the accumulator, sets cls=0 and idx=0.
  - FETCH: frd=1; faddr=idx; waddr=cls*NFEAT+idx; idx increments every cycle. After idx=1023 is issued, the state moves to DRAIN.
  - DRAIN: 2 cycles, frd=0; completes the last product and accumulate.
  - WRITE: 1 cycle.
    - swr=1, saddr=cls, sdata=round_sat(acc).
    - Compares the score with the running max and updates it.
    - If cls==NCLASS-1, go to DONE. Otherwise cls+1, clear acc, idx=0, go to FETCH.
  - DONE: done=1 for 1 cycle, class_id=best index, then IDLE. busy drops in the same cycle the state returns to IDLE.
- Pipeline:
  - Stage 1 registers the signed product of {1'b0,fdata} and wdata: 41-bit signed.
  - Stage 2 adds the sign-extended product into a 52-bit signed accumulator.
  - The pipeline is flushed per class; no product from class c is ever added to class c+1.
- round_sat:
  - Add 2^15 to acc.
  - If the result exceeds 0x7FFFF<<16, output 0x7FFFF.
  - If it is below -(0x80000<<16), output 0x80000.
  - Otherwise output bits [35:16].
- Arg-max:
  - Signed compare, strict greater-than.
  - Ties keep the lower class index.
  - Class 0 always initialises the max.

## Timing
- Reset values: busy=0, frd=0, faddr=0, waddr=0, swr=0, saddr=0, sdata=0, class_id=0, done=0. Internal state is IDLE, acc=0.
- Per class: 1024 FETCH + 2 DRAIN + 1 WRITE = 1027 cycles.
- Latency from ready accepted to done pulse is NCLASS*1027+1 cycles: 4109 for the defaults.
- The first FETCH address appears the cycle after ready is sampled high.
- ready while busy: ignored. ready held high through DONE starts a new run only from IDLE, i.e. the cycle after done.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. A partial score write is never completed.
- swr and done are never high in the same cycle.
- Outputs are registered; sdata and saddr are stable only while swr=1.

## Structure
- Shared package holds:
  - Fixed-point constants: FRAC=16, W=20, ACCW=52, PRODW=41.
  - Saturation limits 0x7FFFF and 0x80000.
  - The state enum IDLE/FETCH/DRAIN/WRITE/DONE.
  - Default NFEAT=1024.
- One sub-module: fc_mac. It is a 2-stage multiply-accumulate with clear, enable and valid inputs and exposes the accumulator.
- FSM, address counters, round_sat and arg-max stay in fc_classify.

## Test plan
- All features 0x10000 (1.0), all weights 0x10000 for NCLASS=4 -> every score 0x7FFFF (1024.0 saturates); class_id=0 (tie rule); done at cycle 4109.
- Feature index 5 = 0x20000, other features 0; class c weight[5] = c*0x08000 -> scores 0x00000, 0x10000, 0x20000, 0x30000; class_id=3.
- All features 0x00001, all weights 0x08000 -> acc=1024*0x8000=2^25, round gives 0x200 (exact); and with weights 0x00001 -> acc=1024, sum below half-LSB, score 0.
- Class 1 weights all 0xF0000 (-1.0), features 0x10000 -> score 0x80000 (negative saturation); class_id never 1.
- Reset asserted at cycle 1500 (class 1 FETCH), released, ready reasserted -> no swr for class 1 before reset; the full sequence restarts from class 0 with correct scores.
- ready pulsed again at cycles 10 and 2000 while busy -> ignored; exactly NCLASS swr pulses and one done.
